// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ requesters,
// with burst locking via req_last and a registered (1-cycle latency) write port.
module regfile_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [NUM_REQ-1:0]            wr_grant,
  output logic                          busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] ptr, ptr_next;
  logic [PTR_W-1:0] owner, owner_next;
  logic [PTR_W-1:0] win_idx, cand, sel;
  logic             win_found, accept, sel_last;

  // Scan from farthest to nearest so the requester closest after ptr overwrites the rest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign sel      = (state == LOCKED) ? owner : win_idx;
  assign sel_last = req_last[sel];
  assign accept   = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= PTR_W'(NUM_REQ - 1);
      owner    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_grant <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      owner    <= owner_next;
      wr_en    <= accept;
      wr_grant <= req_valid & req_ready;
      busy     <= (state_next == LOCKED);
      if (accept) begin
        wr_addr <= req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data <= req_data[sel*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ptr only advances when a burst completes; a lock leaves it untouched.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    if (accept) begin
      if (state == IDLE) begin
        if (sel_last) begin
          ptr_next = sel;
        end else begin
          state_next = LOCKED;
          owner_next = sel;
        end
      end else if (sel_last) begin
        state_next = IDLE;
        ptr_next   = owner;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      if (state == LOCKED) req_ready[owner] = req_valid[owner];
      else if (win_found)  req_ready[win_idx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the round-robin / burst-lock rules.
module tb_regfile_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_last, req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              wr_en, busy;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [N-1:0]      wr_grant;

  regfile_wr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_grant(wr_grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: locked flag, owner index, last-completed index.
  bit            m_locked;
  int            m_owner, m_ptr;
  logic [N-1:0]  e_ready;
  logic          e_wr_en;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [N-1:0]  e_grant;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r = '0;
    if (!rst_n) return r;
    if (m_locked) begin
      r[m_owner] = req_valid[m_owner];
      return r;
    end
    for (int k = 1; k <= N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = N - 1;
    e_wr_en = 0; e_addr = '0; e_data = '0; e_grant = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = req_valid & e_ready;
    e_wr_en = 1'b0;
    e_grant = '0;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        e_wr_en = 1'b1;
        e_grant = N'(1) << i;
        e_addr  = req_addr[i*AW +: AW];
        e_data  = req_data[i*DW +: DW];
        if (req_last[i]) begin
          m_locked = 0;
          m_ptr    = i;
        end else begin
          m_locked = 1;
          m_owner  = i;
        end
      end
    end
  endtask

  // One clock: check ready before the edge, then every registered output after it.
  task automatic step();
    #1;
    e_ready = model_ready();
    chk("req_ready", req_ready, e_ready);
    @(posedge clk);
    model_edge();
    #1;
    chk("wr_en", wr_en, e_wr_en);
    chk("wr_grant", wr_grant, e_grant);
    chk("wr_addr", wr_addr, e_addr);
    chk("wr_data", wr_data, e_data);
    chk("busy", busy, m_locked);
  endtask

  task automatic set_req(input int i, input bit v, input bit l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_all();
    req_valid = '0; req_last = '0; req_addr = '0; req_data = '0;
  endtask

  task automatic do_reset();
    clear_all();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] exp_rr [5];
  logic [N-1:0] hold;

  initial begin
    model_reset();
    e_ready = '0;
    clear_all();

    // Reset then idle
    do_reset();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", wr_grant, 0);
    step();
    chk("idle_ready", req_ready, 0);

    // Round robin, all single-beat
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < N; i++) set_req(i, 1, 1, AW'(i), DW'(32'hA0 + i));
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rr_grant", wr_grant, exp_rr[c]);
      chk("rr_addr", wr_addr, c % N);
      chk("rr_data", wr_data, 32'hA0 + (c % N));
    end

    // Burst lock by req1 with req0/req2 competing; first move ptr to 0
    do_reset();
    set_req(0, 1, 1, 5'd0, 32'h0);
    step();
    set_req(1, 1, 0, 5'd1, 32'h11);
    set_req(2, 1, 1, 5'd2, 32'h20);
    step();
    chk("burst_d1", wr_data, 32'h11);
    chk("burst_busy1", busy, 1);
    set_req(1, 1, 0, 5'd1, 32'h12);
    #1 chk("burst_only1", req_ready, 4'b0010);
    step();
    chk("burst_d2", wr_data, 32'h12);
    chk("burst_busy2", busy, 1);
    set_req(1, 1, 1, 5'd1, 32'h13);
    step();
    chk("burst_d3", wr_data, 32'h13);
    chk("burst_busy3", busy, 0);
    set_req(1, 0, 0, 5'd0, 32'h0);
    step();
    chk("burst_next", wr_grant, 4'b0100);

    // Owner stall: req3 locks then drops valid while req0 waits
    do_reset();
    set_req(3, 1, 0, 5'd3, 32'h30);
    step();
    set_req(3, 0, 0, 5'd3, 32'h30);
    set_req(0, 1, 1, 5'd0, 32'h01);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_wr_en", wr_en, 0);
      chk("stall_rdy0", req_ready[0], 0);
    end
    set_req(3, 1, 1, 5'd3, 32'h31);
    step();
    chk("stall_end", wr_data, 32'h31);
    set_req(3, 0, 0, 5'd0, 32'h0);
    step();
    chk("stall_req0", wr_grant, 4'b0001);

    // Reset in the middle of req2's burst
    do_reset();
    set_req(2, 1, 0, 5'd2, 32'h21);
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_en", wr_en, 0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 1, AW'(i), DW'(i));
    step();
    chk("midrst_first", wr_grant, 4'b0001);

    // Backpressure: req1 waits one cycle behind req0
    do_reset();
    set_req(0, 1, 1, 5'd7, 32'h77);
    set_req(1, 1, 1, 5'd9, 32'hDEAD_BEEF);
    step();
    chk("bp_first", wr_grant, 4'b0001);
    set_req(0, 0, 0, 5'd0, 32'h0);
    step();
    chk("bp_grant", wr_grant, 4'b0010);
    chk("bp_addr", wr_addr, 5'd9);
    chk("bp_data", wr_data, 32'hDEAD_BEEF);

    // Randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      hold  = req_valid & ~e_ready;
      rst_n = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          set_req(i, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                  AW'($urandom), DW'($urandom));
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin write-port arbiter that shares the single write port of a register file (built from the library's register primitives) among `NUM_REQ` requesters. Each requester presents address/data beats over a valid/ready handshake. A requester can lock the port for a multi-beat burst using `req_last`. The winning beat is registered and driven onto the register file write port one cycle after acceptance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `ADDR_WIDTH`, default 5: register file address width.
- `DATA_WIDTH`, default 32: register file data width.

Ports:
- `clk`  input  1: single clock; all logic on its rising edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `req_valid`  input  NUM_REQ: per-requester beat valid.
- `req_last`  input  NUM_REQ: beat is the final beat of a burst; a single-beat write has last=1.
- `req_addr`  input  NUM_REQ*ADDR_WIDTH: packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data`  input  NUM_REQ*DATA_WIDTH: packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  output  NUM_REQ: per-requester accept; combinational, at most one bit set.
- `wr_en`  output  1: register file write enable; registered.
- `wr_addr`  output  ADDR_WIDTH: write address; registered.
- `wr_data`  output  DATA_WIDTH: write data; registered.
- `wr_grant`  output  NUM_REQ: one-hot source of the current `wr_*` beat; all-zero when `wr_en`=0; registered.
- `busy`  output  1: high while the port is locked by a burst owner (state LOCKED); registered.

## Operation
- State machine:
  - IDLE: arbitrate among all valid requesters.
  - LOCKED: only the owner is served.
- Round-robin pointer `ptr` holds the index of the last requester whose burst completed.
  - Search order is ptr+1, ptr+2, …, wrapping modulo NUM_REQ.
  - The first requester in that order with `req_valid`=1 wins.
- Behaviour in IDLE:
  - `req_ready` is asserted only for the winner, and only while its `req_valid`=1.
  - With no valid requesters, `req_ready`=0.
- Behaviour in LOCKED:
  - `req_ready[owner]` = `req_valid[owner]`.
  - All other ready bits are 0, regardless of their valid.
- A beat is accepted when `req_valid[i]` & `req_ready[i]`. On acceptance:
  - The winner's last=1 in IDLE: stay in IDLE and set ptr := winner.
  - The winner's last=0 in IDLE: go to LOCKED and set owner := winner; ptr is unchanged.
  - The owner's last=1 in LOCKED: go to IDLE and set ptr := owner.
  - The owner's last=0 in LOCKED: stay in LOCKED.
- If the owner deasserts valid while in LOCKED:
  - The port stays LOCKED indefinitely and no other requester is served.
  - There is no timeout.
- `req_ready` may depend combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Requesters hold addr, data and last stable while valid=1 and ready=0.
- Reset (`rst_n`=0 at a rising edge) applies regardless of any other input:
  - State := IDLE, ptr := NUM_REQ-1, owner := 0.
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_grant`=0, `busy`=0.
  - A burst in progress is abandoned; no partial beat is written after reset.
- While `rst_n`=0, `req_ready` is forced to 0.

## Timing
- Write latency is 1 cycle. A beat accepted in cycle N appears as `wr_en`=1, with its addr/data and `wr_grant`, in cycle N+1.
- Throughput is one beat per cycle:
  - Back-to-back bursts from the same or different requesters incur no bubble.
  - The IDLE→LOCKED and LOCKED→IDLE transitions take effect in the cycle after the accepting edge.
- `busy` rises in the cycle after a last=0 beat is accepted in IDLE. It falls in the cycle after the owner's last=1 beat is accepted.
- In a cycle with no accepted beat, `wr_en`=0 and `wr_grant`=0. `wr_addr` and `wr_data` hold their previous values.
- Fairness: with all requesters continuously valid and single-beat, grants rotate 0,1,…,NUM_REQ-1,0,… with no starvation.

## Test plan
- Reset then all idle: `rst_n`=0 for 2 cycles, then all valid=0 → all outputs 0, `req_ready`=0, `busy`=0.
- Round robin: NUM_REQ=4, all four valid with last=1 continuously, addr=i, data=0xA0+i → `wr_grant` sequence 0001,0010,0100,1000,0001 on consecutive cycles; `wr_addr` sequence 0,1,2,3,0 on those cycles, starting one cycle after the first acceptance.
- Burst lock: req1 sends 3 beats (last=0,0,1, data 0x11,0x12,0x13) while req0 and req2 stay valid → `busy`=1 for the cycles after beats 1 and 2; only `req_ready[1]` is high; writes 0x11,0x12,0x13 are written back-to-back; the next grant goes to req2.
- Owner stall: req3 sends last=0, drops valid for 5 cycles while req0 is valid → `req_ready[0]` stays 0 and `wr_en`=0 for those 5 cycles; req3 then sends last=1, after which req0 is granted.
- Reset mid-burst: `rst_n`=0 in the cycle after req2's first beat (last=0) → next cycle `busy`=0 and `wr_en`=0; after release, req0 wins first (ptr=NUM_REQ-1).
- Backpressure hold: req0 and req1 are valid, and req1 is not selected for 1 cycle → req1 holds addr/data, is accepted the next cycle, and the written values match its held inputs.
